uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single uart_tx serializer among NUM_REQ telemetry sources (sensor, PID, status).
//  Round-robin grant at packet granularity; a granted source streams bytes over valid/ready
//  until a byte flagged last has been serialized. Replaces per-source hard-wired UART FSMs.
// PARAMETERS
//  NUM_REQ        4        number of requesters, 2..8
//  CLKS_PER_BIT   1085     passed to uart_tx (115200 baud @ 125 MHz)
//  TIMEOUT_CYCLES 125000   stall limit while holding grant (UART_ARB_TIMEOUT_EN only)
// PORTS
//  clk         in   1            system clock
//  reset       in   1            asynchronous, active-high
//  req_valid   in   NUM_REQ      requester i has a byte on req_data[i]
//  req_data    in   NUM_REQ*8    byte for requester i in bits [8i+7:8i]
//  req_last    in   NUM_REQ      byte on req_data[i] ends its packet
//  req_ready   out  NUM_REQ      byte of requester i accepted this cycle
//  grant_id    out  $clog2(NUM_REQ) current owner, valid while busy=1
//  busy        out  1            a packet is in progress
//  pkt_done    out  1            1-cycle pulse: last byte of a packet fully serialized
//  timeout_err out  1            1-cycle pulse: packet aborted on stall
//  serial_tx   out  1            UART line, idle high
// BEHAVIOUR
//  Reset (clk, reset: asynchronous, active-high): state=IDLE, rr_ptr=0, grant_id=0, busy=0,
//   req_ready=0, pkt_done=0, timeout_err=0, start_tx=0, tx_byte=0; serial_tx=1 (uart_tx reset).
//  States: IDLE -> LOAD -> WAIT_DONE -> (LOAD | IDLE).
//  IDLE: if any req_valid, winner = first asserted index searching rr_ptr, rr_ptr+1, ... mod
//   NUM_REQ; register grant_id=winner, busy=1, go LOAD. No valid -> stay IDLE.
//  LOAD: req_ready[i] = (state==LOAD) && (i==grant_id), combinational, all others 0.
//   On req_valid[grant_id]: capture byte and last, start_tx=1 for exactly 1 cycle next cycle,
//   go WAIT_DONE. valid/ready handshake: a byte transfers only when both high same cycle.
//  WAIT_DONE: wait for uart_tx done pulse. Then: last captured -> pkt_done=1 one cycle,
//   busy=0, rr_ptr=(grant_id+1) mod NUM_REQ, IDLE; else -> LOAD for next byte.
//  Latency: valid in IDLE -> req_ready 1 cycle later; handshake -> start_tx next cycle.
//  Non-granted requesters' valids are ignored (never dropped; they hold until granted).
//  Grant never changes mid-packet; a winner whose valid drops in LOAD keeps the grant.
//  Simultaneous valids: round-robin guarantees each requester within NUM_REQ packets.
//  req_valid of owner dropping/rising during WAIT_DONE has no effect (ready is 0).
//  pkt_done returning to IDLE with other valids pending: new grant decided in IDLE (1 cycle
//   gap minimum between packets).
//  Reset mid-byte: line returns high immediately; partial packet discarded, no pulses.
// CONFIGURATION
//  `UART_ARB_TIMEOUT_EN defined: counter clears on entering LOAD and on each handshake,
//   increments each LOAD cycle with owner valid low; at TIMEOUT_CYCLES-1 -> timeout_err=1
//   one cycle, busy=0, rr_ptr=(grant_id+1) mod NUM_REQ, IDLE; no pkt_done.
//  Not defined: no counter, timeout_err tied 0; owner may hold LOAD indefinitely.
// STRUCTURE
//  Package uart_arb_pkg: arb_state_t enum {ARB_IDLE, ARB_LOAD, ARB_WAIT_DONE},
//   UART_BYTE_W=8 constant.
//  Instantiates existing uart_tx (DATA_WIDTH=8, CLKS_PER_BIT) unchanged.
//  One sub-module: rr_select (combinational: valid vector + rr_ptr -> winner, any).
// TESTING (CLKS_PER_BIT=4 for sim, NUM_REQ=4, TIMEOUT_CYCLES=50)
//  1 Req 2 sends 0x48,0x49(last) -> two frames 0x48,0x49 on serial_tx, grant_id=2,
//    one pkt_done, rr_ptr=3.
//  2 Reqs 0,1,3 valid together from reset -> packet order 0,1,3,0...; no interleaved bytes.
//  3 Owner 1 drops valid 20 cycles between bytes -> grant held, no other requester served.
//  4 TIMEOUT_EN: owner stalls 50 cycles -> timeout_err pulse, busy=0, next requester
//    granted; without macro stays busy, timeout_err=0.
//  5 Reset asserted mid-frame -> serial_tx=1 same cycle, busy=0, no pulses; clean
//    packet after release.
//  6 Checker: start_tx one cycle per accepted byte; req_ready one-hot or zero; decoded
//    UART stream equals per-requester input packets.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_LOAD,
        ARB_WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin winner search: first asserted valid starting at ptr, wrapping.
module rr_select #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    // Scan from ptr upward modulo NUM_REQ, keep the first hit
    always_comb begin : pick
        int unsigned idx;
        idx    = 0;
        winner = '0;
        any    = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!any && valid[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART serializer: start bit, DATA_WIDTH data bits LSB first, one stop bit.
// Each bit lasts CLKS_PER_BIT cycles; done pulses once after the stop bit.
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  tx,
    output logic                  done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    tx_state_t             state;
    tx_state_t             state_next;
    logic [CW-1:0]         clk_cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  bit_end;
    logic                  last_bit;

    assign bit_end  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    assign last_bit = (bit_idx == BW'(DATA_WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= TX_IDLE;
        else       state <= state_next;
    end

    // Next-state: advance one frame field per completed bit period
    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE:  if (start)               state_next = TX_START;
            TX_START: if (bit_end)             state_next = TX_DATA;
            TX_DATA:  if (bit_end && last_bit) state_next = TX_STOP;
            TX_STOP:  if (bit_end)             state_next = TX_IDLE;
            default:                           state_next = TX_IDLE;
        endcase
    end

    // Bit timing, shift register and line driver
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == TX_IDLE) begin
                clk_cnt <= '0;
                bit_idx <= '0;
                if (start) begin
                    shreg <= data;
                    tx    <= 1'b0;
                end
            end else begin
                clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
                if (bit_end) begin
                    case (state)
                        TX_START: begin
                            tx    <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                        TX_DATA: begin
                            bit_idx <= bit_idx + 1'b1;
                            if (last_bit) begin
                                tx <= 1'b1;
                            end else begin
                                tx    <= shreg[0];
                                shreg <= shreg >> 1;
                            end
                        end
                        TX_STOP: done <= 1'b1;
                        default: tx <= 1'b1;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NUM_REQ sources.
// Optional stall abort when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int CLKS_PER_BIT   = 1085,
    parameter  int TIMEOUT_CYCLES = 125000,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [IDX_W-1:0]               grant_id,
    output logic                           busy,
    output logic                           pkt_done,
    output logic                           timeout_err,
    output logic                           serial_tx
);

    arb_state_t             state;
    arb_state_t             state_next;
    logic [IDX_W-1:0]       rr_ptr;
    logic [IDX_W-1:0]       rr_ptr_next;
    logic [IDX_W-1:0]       grant_next;
    logic [IDX_W-1:0]       grant_plus1;
    logic                   busy_next;
    logic                   pkt_done_next;
    logic                   timeout_next;
    logic                   start_tx;
    logic                   start_next;
    logic [UART_BYTE_W-1:0] tx_byte;
    logic [UART_BYTE_W-1:0] tx_byte_next;
    logic                   last_q;
    logic                   last_next;
    logic                   tx_done;
    logic [IDX_W-1:0]       winner;
    logic                   any_valid;
    logic                   owner_valid;
    logic [UART_BYTE_W-1:0] owner_byte;
    logic                   owner_last;
    logic                   to_hit;

    rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .valid  (req_valid),
        .ptr    (rr_ptr),
        .winner (winner),
        .any    (any_valid)
    );

    uart_tx #(
        .DATA_WIDTH   (UART_BYTE_W),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .start (start_tx),
        .data  (tx_byte),
        .tx    (serial_tx),
        .done  (tx_done)
    );

    assign grant_plus1 = (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Select the current owner's valid/data/last
    always_comb begin
        owner_valid = 1'b0;
        owner_byte  = '0;
        owner_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == grant_id) begin
                owner_valid = req_valid[i];
                owner_byte  = req_data[i*UART_BYTE_W +: UART_BYTE_W];
                owner_last  = req_last[i];
            end
        end
    end

    // Ready only for the owner while waiting for its next byte
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == ARB_LOAD) && (IDX_W'(i) == grant_id);
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state == ARB_LOAD) && !owner_valid &&
                    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Stall counter: counts LOAD cycles with owner valid low, cleared otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  to_cnt <= '0;
        else if (state != ARB_LOAD || owner_valid) to_cnt <= '0;
        else                                        to_cnt <= to_cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            pkt_done    <= 1'b0;
            timeout_err <= 1'b0;
            start_tx    <= 1'b0;
            tx_byte     <= '0;
            last_q      <= 1'b0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_ptr_next;
            grant_id    <= grant_next;
            busy        <= busy_next;
            pkt_done    <= pkt_done_next;
            timeout_err <= timeout_next;
            start_tx    <= start_next;
            tx_byte     <= tx_byte_next;
            last_q      <= last_next;
        end
    end

    // Next-state and next-output decisions
    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        grant_next    = grant_id;
        busy_next     = busy;
        pkt_done_next = 1'b0;
        timeout_next  = 1'b0;
        start_next    = 1'b0;
        tx_byte_next  = tx_byte;
        last_next     = last_q;
        case (state)
            ARB_IDLE: begin
                if (any_valid) begin
                    grant_next = winner;
                    busy_next  = 1'b1;
                    state_next = ARB_LOAD;
                end
            end
            ARB_LOAD: begin
                if (owner_valid) begin
                    tx_byte_next = owner_byte;
                    last_next    = owner_last;
                    start_next   = 1'b1;
                    state_next   = ARB_WAIT_DONE;
                end else if (to_hit) begin
                    timeout_next = 1'b1;
                    busy_next    = 1'b0;
                    rr_ptr_next  = grant_plus1;
                    state_next   = ARB_IDLE;
                end
            end
            ARB_WAIT_DONE: begin
                if (tx_done) begin
                    if (last_q) begin
                        pkt_done_next = 1'b1;
                        busy_next     = 1'b0;
                        rr_ptr_next   = grant_plus1;
                        state_next    = ARB_IDLE;
                    end else begin
                        state_next = ARB_LOAD;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a packet-level round-robin model
// and an independent UART line decoder.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int CPB   = 4;
    localparam int TO    = 50;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*8-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic [IDX_W-1:0] grant_id;
    logic             busy;
    logic             pkt_done;
    logic             timeout_err;
    logic             serial_tx;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .CLKS_PER_BIT   (CPB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant_id    (grant_id),
        .busy        (busy),
        .pkt_done    (pkt_done),
        .timeout_err (timeout_err),
        .serial_tx   (serial_tx)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [8:0] src_q [N][$];
    logic [7:0] exp_bytes[$];
    logic [7:0] obs_bytes[$];
    int         exp_grants[$];
    int         obs_grants[$];
    int         model_ptr = 0;
    int         exp_pkts = 0;
    int         pkt_done_cnt = 0;
    int         to_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first requester with a pending packet at or after ptr.
    function automatic int rr_pick(input bit [N-1:0] pend, input int ptr);
        for (int k = 0; k < N; k++)
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic add_packet(input int r, input int len);
        for (int b = 0; b < len; b++)
            src_q[r].push_back({(b == len - 1), 8'($urandom)});
    endtask

    // Expected grant order and byte stream from the queued packets.
    task automatic plan();
        logic [8:0] m [N][$];
        bit [N-1:0] pend;
        int w;
        logic [8:0] b;
        for (int i = 0; i < N; i++) m[i] = src_q[i];
        forever begin
            for (int i = 0; i < N; i++) pend[i] = (m[i].size() > 0);
            if (pend == '0) break;
            w = rr_pick(pend, model_ptr);
            exp_grants.push_back(w);
            do begin
                b = m[w].pop_front();
                exp_bytes.push_back(b[7:0]);
            end while (!b[8]);
            exp_pkts++;
            model_ptr = (w + 1) % N;
        end
    endtask

    task automatic clear_sb();
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_bytes.delete();
        obs_bytes.delete();
        exp_grants.delete();
        obs_grants.delete();
        exp_pkts = 0;
        pkt_done_cnt = 0;
        to_cnt = 0;
    endtask

    task automatic finish_scenario(input string name, input int exp_to);
        check_eq({name, "_grant_count"}, obs_grants.size(), exp_grants.size());
        for (int k = 0; k < exp_grants.size() && k < obs_grants.size(); k++)
            check_eq({name, "_grant"}, obs_grants[k], exp_grants[k]);
        check_eq({name, "_byte_count"}, obs_bytes.size(), exp_bytes.size());
        for (int k = 0; k < exp_bytes.size() && k < obs_bytes.size(); k++)
            check_eq({name, "_byte"}, obs_bytes[k], exp_bytes[k]);
        check_eq({name, "_pkt_done"}, pkt_done_cnt, exp_pkts);
        check_eq({name, "_timeout_err"}, to_cnt, exp_to);
        clear_sb();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
        clear_sb();
    endtask

    // Drive all queued packets; owners may stall mid-packet, never before their first byte.
    task automatic run_traffic(input int fixed_stall);
        bit [N-1:0] hs;
        int stall[N];
        bit fin;
        bit empty;
        logic [8:0] b;
        hs  = '0;
        fin = 1'b0;
        for (int i = 0; i < N; i++) stall[i] = 0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    b = src_q[i].pop_front();
                    if (!b[8])
                        stall[i] = (fixed_stall >= 0) ? fixed_stall :
                                   (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0);
                end
                if (stall[i] > 0) begin
                    stall[i]--;
                    req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = (src_q[i].size() > 0);
                end
                if (src_q[i].size() > 0) {req_last[i], req_data[i*8 +: 8]} = src_q[i][0];
            end
            hs = req_valid & req_ready;
            empty = 1'b1;
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) empty = 1'b0;
            fin = empty && (pkt_done_cnt == exp_pkts);
        end
        if (!fin) check_eq("traffic_budget", 0, 1);
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    // UART line decoder, sampling mid-bit on falling clock edges
    initial begin : decoder
        bit dact;
        int dc;
        int k;
        logic [7:0] dsh;
        dact = 1'b0;
        dc   = 0;
        dsh  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                dact = 1'b0;
            end else begin
                if (!dact && serial_tx === 1'b0) begin
                    dact = 1'b1;
                    dc   = 0;
                end else if (dact) begin
                    dc++;
                end
                if (dact && (dc % CPB) == CPB / 2) begin
                    k = dc / CPB;
                    if (k == 0) check_eq("start_bit", serial_tx, 0);
                    else if (k <= 8) dsh[k-1] = serial_tx;
                    else begin
                        check_eq("stop_bit", serial_tx, 1);
                        obs_bytes.push_back(dsh);
                        dact = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle protocol checks and grant/pulse capture
    initial begin : monitor
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check_eq("ready_onehot0", $onehot0(req_ready), 1);
                if (req_ready != '0) begin
                    check_eq("ready_owner", req_ready, 32'(1) << grant_id);
                    check_eq("ready_busy", busy, 1);
                end
                if (busy && !prev_busy) obs_grants.push_back(grant_id);
                if (pkt_done) pkt_done_cnt++;
                if (timeout_err) to_cnt++;
            end
            prev_busy = busy;
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        bit got;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_pkt_done", pkt_done, 0);
        check_eq("rst_timeout", timeout_err, 0);
        check_eq("rst_serial", serial_tx, 1);
        apply_reset();

        // Requester 2 sends 0x48, 0x49
        src_q[2].push_back({1'b0, 8'h48});
        src_q[2].push_back({1'b1, 8'h49});
        plan();
        run_traffic(-1);
        finish_scenario("req2", 0);

        // Pointer now past 2: requester 3 must win over 0
        add_packet(0, 1);
        add_packet(3, 2);
        plan();
        run_traffic(-1);
        finish_scenario("rr_after2", 0);

        // Requesters 0,1,3 together from reset
        apply_reset();
        add_packet(0, 2);
        add_packet(0, 1);
        add_packet(1, 3);
        add_packet(3, 2);
        plan();
        run_traffic(-1);
        finish_scenario("trio", 0);

        // Owners stall 20 cycles between bytes while others wait
        add_packet(1, 3);
        add_packet(0, 2);
        add_packet(2, 1);
        plan();
        run_traffic(20);
        finish_scenario("stall", 0);

        // Random packet mixes
        for (int r = 0; r < 6; r++) begin
            n = 0;
            for (int i = 0; i < N; i++) begin
                int npk;
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    add_packet(i, $urandom_range(1, 4));
                    n++;
                end
            end
            if (n == 0) add_packet(r % N, 2);
            plan();
            run_traffic(-1);
            finish_scenario("random", 0);
        end

        // Owner 1 stalls forever after its first byte; requester 2 waits
        apply_reset();
        req_data[15:8]  = 8'hA1;
        req_last[1]     = 1'b0;
        req_valid[1]    = 1'b1;
        req_data[23:16] = 8'hC3;
        req_last[2]     = 1'b1;
        req_valid[2]    = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        check_eq("to_first_ready", got, 1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        exp_grants.push_back(1);
        exp_bytes.push_back(8'hA1);
`ifdef UART_ARB_TIMEOUT_EN
        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (timeout_err) got = 1'b1;
            else if (req_ready[1]) n++;
        end
        check_eq("to_seen", got, 1);
        check_eq("to_cycles", n, TO);
        check_eq("to_busy", busy, 0);
        check_eq("to_no_pkt_done", pkt_done_cnt, 0);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[2]) got = 1'b1;
        end
        check_eq("to_next_ready", got, 1);
        @(negedge clk);
        req_valid[2] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (pkt_done) got = 1'b1;
        end
        check_eq("to_next_done", got, 1);
        repeat (2) @(negedge clk);
        exp_grants.push_back(2);
        exp_bytes.push_back(8'hC3);
        exp_pkts = 1;
        finish_scenario("timeout", 1);
`else
        repeat (300) @(negedge clk);
        check_eq("hold_busy", busy, 1);
        check_eq("hold_grant", grant_id, 1);
        check_eq("hold_ready", req_ready, 4'b0010);
        finish_scenario("hold", 0);
`endif
        apply_reset();

        // Reset in the middle of a frame
        req_data[7:0] = 8'h5A;
        req_last[0]   = 1'b1;
        req_valid[0]  = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (serial_tx == 1'b0) got = 1'b1;
        end
        check_eq("mid_frame_started", got, 1);
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("mid_rst_serial", serial_tx, 1);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ready", req_ready, 0);
        check_eq("mid_rst_pkt_done", pkt_done, 0);
        check_eq("mid_rst_timeout", timeout_err, 0);
        req_valid = '0;
        repeat (3) @(negedge clk);
        check_eq("mid_rst_no_bytes", obs_bytes.size(), 0);
        check_eq("mid_rst_no_pulses", pkt_done_cnt + to_cnt, 0);
        reset = 1'b0;
        model_ptr = 0;
        clear_sb();
        add_packet(3, 2);
        add_packet(1, 1);
        plan();
        run_traffic(-1);
        finish_scenario("post_reset", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
